// File: rtl/ysyx_25040129_lsu.sv
// ysyx_25040129_lsu -- load/store unit
//
// Sits behind the execute stage. It takes one request at a time and does at
// most one AXI-lite style bus access per request, on a word-aligned address
// with byte lanes. The result goes back to the write-back stage through a
// valid/ready handshake. A request with no memory access is an ALU
// pass-through: req_addr comes back unchanged one cycle later.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready              request handshake from the execute stage
//   req_addr, req_wdata              address (or ALU result), unshifted store data
//   req_read, req_write, req_tag     access kind and the opaque sideband
//   araddr/arvalid/arready           read address channel
//   rdata/rresp/rvalid               read data channel (always accepted in R)
//   awaddr/wdata/wstrb/awvalid/awready   write address+data, one beat
//   bresp/bvalid                     write response (always accepted in B)
//   wb_valid/wb_ready                result handshake to write-back
//   wb_data, wb_tag, wb_fault        result, returned sideband, fault flag
module ysyx_25040129_lsu #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [2:0]       req_read,
    input  logic [1:0]       req_write,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      araddr,
    output logic             arvalid,
    input  logic             arready,
    input  logic [31:0]      rdata,
    input  logic [1:0]       rresp,
    input  logic             rvalid,
    output logic [31:0]      awaddr,
    output logic [31:0]      wdata,
    output logic [3:0]       wstrb,
    output logic             awvalid,
    input  logic             awready,
    input  logic [1:0]       bresp,
    input  logic             bvalid,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [31:0]      wb_data,
    output logic [TAG_W-1:0] wb_tag,
    output logic             wb_fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_B,
        S_WB
    } state_t;

    state_t             state_reg, state_next;
    logic [31:0]        addr_reg, addr_next;
    logic [2:0]         read_reg, read_next;
    logic [31:0]        wdata_reg, wdata_next;
    logic [3:0]         wstrb_reg, wstrb_next;
    logic [TAG_W-1:0]   tag_reg, tag_next;
    logic [31:0]        wb_data_reg, wb_data_next;
    logic               wb_fault_reg, wb_fault_next;

    // Request decode: store size in bytes (0 when not a store) and alignment.
    logic [2:0]  store_size;
    logic        req_misaligned;
    logic [3:0]  req_strb;

    always_comb begin
        store_size = 3'd0;
        case (req_write)
            2'b01:   store_size = 3'd1;
            2'b10:   store_size = 3'd2;
            2'b11:   store_size = 3'd4;
            default: store_size = 3'd0;
        endcase
    end

    // Stores take priority, so alignment is judged on the store size when
    // both fields are set.
    always_comb begin
        req_misaligned = 1'b0;
        if (req_write != 2'b00) begin
            case (req_write)
                2'b10:   req_misaligned = req_addr[0];
                2'b11:   req_misaligned = |req_addr[1:0];
                default: req_misaligned = 1'b0;
            endcase
        end else begin
            case (req_read)
                3'b010, 3'b101: req_misaligned = req_addr[0];
                3'b011:         req_misaligned = |req_addr[1:0];
                default:        req_misaligned = 1'b0;
            endcase
        end
    end

    // Byte strobe: lane gi is enabled when off <= gi < off + size. A
    // non-store has size 0 and so gets an all-zero strobe.
    logic [3:0] lane_lo;
    logic [3:0] lane_hi;
    assign lane_lo = {2'b00, req_addr[1:0]};
    assign lane_hi = lane_lo + {1'b0, store_size};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_strb
            assign req_strb[gi] = (lane_lo <= 4'(gi)) && (4'(gi) < lane_hi);
        end
    endgenerate

    // Load path: bring the addressed lane down to bit 0, then extend it.
    logic [31:0] load_shifted;
    logic [31:0] load_value;
    assign load_shifted = rdata >> {addr_reg[1:0], 3'b000};

    always_comb begin
        load_value = rdata;
        case (read_reg)
            3'b001:  load_value = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b010:  load_value = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b100:  load_value = {24'd0, load_shifted[7:0]};
            3'b101:  load_value = {16'd0, load_shifted[15:0]};
            default: load_value = rdata;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        read_next     = read_reg;
        wdata_next    = wdata_reg;
        wstrb_next    = wstrb_reg;
        tag_next      = tag_reg;
        wb_data_next  = wb_data_reg;
        wb_fault_next = wb_fault_reg;

        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    addr_next     = req_addr;
                    read_next     = req_read;
                    tag_next      = req_tag;
                    wdata_next    = req_wdata << {req_addr[1:0], 3'b000};
                    wstrb_next    = req_strb;
                    wb_data_next  = 32'd0;
                    wb_fault_next = 1'b0;
                    if (req_misaligned) begin
                        wb_fault_next = 1'b1;
                        state_next    = S_WB;
                    end else if (req_write != 2'b00) begin
                        state_next = S_AW;
                    end else if (req_read != 3'b000) begin
                        state_next = S_AR;
                    end else begin
                        wb_data_next = req_addr;
                        state_next   = S_WB;
                    end
                end
            end
            S_AR: begin
                if (arready) begin
                    state_next = S_R;
                end
            end
            S_R: begin
                if (rvalid) begin
                    state_next = S_WB;
                    if (rresp != 2'b00) begin
                        wb_fault_next = 1'b1;
                        wb_data_next  = 32'd0;
                    end else begin
                        wb_data_next = load_value;
                    end
                end
            end
            S_AW: begin
                if (awready) begin
                    state_next = S_B;
                end
            end
            S_B: begin
                if (bvalid) begin
                    state_next    = S_WB;
                    wb_data_next  = 32'd0;
                    wb_fault_next = (bresp != 2'b00);
                end
            end
            S_WB: begin
                if (wb_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            addr_reg     <= 32'd0;
            read_reg     <= 3'd0;
            wdata_reg    <= 32'd0;
            wstrb_reg    <= 4'd0;
            tag_reg      <= '0;
            wb_data_reg  <= 32'd0;
            wb_fault_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            read_reg     <= read_next;
            wdata_reg    <= wdata_next;
            wstrb_reg    <= wstrb_next;
            tag_reg      <= tag_next;
            wb_data_reg  <= wb_data_next;
            wb_fault_reg <= wb_fault_next;
        end
    end

    // Valids are pure decodes of the state register, so they cannot glitch
    // and stay up (with stable payload) until the state moves on.
    assign req_ready = (state_reg == S_IDLE);
    assign arvalid   = (state_reg == S_AR);
    assign awvalid   = (state_reg == S_AW);
    assign wb_valid  = (state_reg == S_WB);
    assign araddr    = {addr_reg[31:2], 2'b00};
    assign awaddr    = {addr_reg[31:2], 2'b00};
    assign wdata     = wdata_reg;
    assign wstrb     = wstrb_reg;
    assign wb_data   = wb_data_reg;
    assign wb_tag    = tag_reg;
    assign wb_fault  = wb_fault_reg;

endmodule

// File: tb/tb_ysyx_25040129_lsu.sv
// Self-checking bench for ysyx_25040129_lsu: directed vector table,
// a reset-while-in-R sequence, and randomized requests checked against
// an arithmetic reference model.
module tb_ysyx_25040129_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_read;
    logic [1:0]  req_write;
    logic [5:0]  req_tag;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic [31:0] awaddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awvalid;
    logic        awready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [5:0]  wb_tag;
    logic        wb_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_25040129_lsu #(.TAG_W(6)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_read(req_read), .req_write(req_write), .req_tag(req_tag),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
        .awaddr(awaddr), .wdata(wdata), .wstrb(wstrb),
        .awvalid(awvalid), .awready(awready),
        .bresp(bresp), .bvalid(bvalid),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_tag(wb_tag), .wb_fault(wb_fault)
    );

    // bus: 0 = no bus access, 1 = read, 2 = write
    typedef struct {
        logic [2:0]  rd;
        logic [1:0]  wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [5:0]  tag;
        logic [31:0] rdat;
        logic [1:0]  resp;
        int          bus;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic [31:0] e_data;
        logic        e_fault;
    } vec_t;

    function automatic vec_t mk(logic [2:0] rd, logic [1:0] wr, logic [31:0] addr,
                                logic [31:0] wd, logic [5:0] tag, logic [31:0] rdat,
                                logic [1:0] resp, int bus, logic [31:0] e_addr,
                                logic [31:0] e_wdata, logic [3:0] e_wstrb,
                                logic [31:0] e_data, logic e_fault);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.tag = tag;
        v.rdat = rdat; v.resp = resp; v.bus = bus; v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_wstrb = e_wstrb; v.e_data = e_data;
        v.e_fault = e_fault;
        return v;
    endfunction

    // Reference model: sizes in bytes, alignment by remainder, lanes by
    // multiplication, sign extension by adding/subtracting powers of two.
    function automatic vec_t model(vec_t v);
        vec_t   r = v;
        longint off, size, sh, val;
        bit     sgn;
        off  = longint'(v.addr) % 4;
        size = 0;
        sgn  = 0;
        r.e_addr = 32'(longint'(v.addr) - off);
        r.e_wdata = 0;
        r.e_wstrb = 0;
        r.e_data = 0;
        r.e_fault = 0;
        if (v.wr != 0) begin
            size = (v.wr == 3) ? 4 : longint'(v.wr);
            if (off % size != 0) begin
                r.bus = 0; r.e_fault = 1;
            end else begin
                r.bus = 2;
                r.e_wdata = 32'(longint'(v.wd) * (longint'(1) << (8 * off)));
                r.e_wstrb = 4'(((longint'(1) << size) - 1) << off);
                r.e_fault = (v.resp != 0);
            end
        end else if (v.rd != 0) begin
            case (v.rd)
                1: begin size = 1; sgn = 1; end
                2: begin size = 2; sgn = 1; end
                3: size = 4;
                4: size = 1;
                default: size = 2;
            endcase
            if (off % size != 0) begin
                r.bus = 0; r.e_fault = 1;
            end else begin
                r.bus = 1;
                if (v.resp != 0) begin
                    r.e_fault = 1;
                end else begin
                    sh  = longint'(v.rdat) / (longint'(1) << (8 * off));
                    val = sh % (longint'(1) << (8 * size));
                    if (sgn && val >= (longint'(1) << (8 * size - 1)))
                        val = val + (longint'(1) << 32) - (longint'(1) << (8 * size));
                    r.e_data = 32'(val);
                end
            end
        end else begin
            r.bus = 0;
            r.e_data = v.addr;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v, input int ar_dly, input int rsp_dly,
                           input int wb_dly, input string nm);
        chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
        req_addr = v.addr; req_wdata = v.wd; req_read = v.rd;
        req_write = v.wr; req_tag = v.tag; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_tag = 6'($urandom);
        if (v.bus == 1) begin
            for (int i = 0; i <= ar_dly; i++) begin
                chk({nm, " arvalid"}, 32'(arvalid), 32'd1);
                chk({nm, " araddr"}, araddr, v.e_addr);
                chk({nm, " awvalid"}, 32'(awvalid), 32'd0);
                arready = (i == ar_dly);
                rvalid = 1'b1; rresp = 2'b11; rdata = $urandom;  // must be ignored in AR
                tick();
            end
            arready = 1'b0;
            for (int i = 0; i <= rsp_dly; i++) begin
                chk({nm, " arvalid_low"}, 32'(arvalid), 32'd0);
                chk({nm, " wb_valid_early"}, 32'(wb_valid), 32'd0);
                rvalid = (i == rsp_dly);
                rdata  = (i == rsp_dly) ? v.rdat : $urandom;
                rresp  = (i == rsp_dly) ? v.resp : 2'b00;
                tick();
            end
            rvalid = 1'b0;
        end else if (v.bus == 2) begin
            for (int i = 0; i <= ar_dly; i++) begin
                chk({nm, " awvalid"}, 32'(awvalid), 32'd1);
                chk({nm, " awaddr"}, awaddr, v.e_addr);
                chk({nm, " wdata"}, wdata, v.e_wdata);
                chk({nm, " wstrb"}, 32'(wstrb), 32'(v.e_wstrb));
                chk({nm, " arvalid"}, 32'(arvalid), 32'd0);
                awready = (i == ar_dly);
                bvalid = 1'b1; bresp = 2'b10;  // must be ignored in AW
                tick();
            end
            awready = 1'b0;
            for (int i = 0; i <= rsp_dly; i++) begin
                chk({nm, " awvalid_low"}, 32'(awvalid), 32'd0);
                chk({nm, " wb_valid_early"}, 32'(wb_valid), 32'd0);
                bvalid = (i == rsp_dly);
                bresp  = (i == rsp_dly) ? v.resp : 2'b00;
                tick();
            end
            bvalid = 1'b0;
        end else begin
            chk({nm, " arvalid_none"}, 32'(arvalid), 32'd0);
            chk({nm, " awvalid_none"}, 32'(awvalid), 32'd0);
        end
        for (int i = 0; i <= wb_dly; i++) begin
            chk({nm, " wb_valid"}, 32'(wb_valid), 32'd1);
            chk({nm, " wb_data"}, wb_data, v.e_data);
            chk({nm, " wb_tag"}, 32'(wb_tag), 32'(v.tag));
            chk({nm, " wb_fault"}, 32'(wb_fault), 32'(v.e_fault));
            chk({nm, " req_ready_busy"}, 32'(req_ready), 32'd0);
            wb_ready = (i == wb_dly);
            tick();
        end
        wb_ready = 1'b0;
        chk({nm, " wb_valid_done"}, 32'(wb_valid), 32'd0);
        $display("txn %s rd=%0d wr=%0d addr=%08h data=%08h fault=%0b tag=%02h",
                 nm, v.rd, v.wr, v.addr, wb_data, wb_fault, wb_tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[14];
        vec_t v;

        tbl[0]  = mk(3'd1, 2'd0, 32'h80000003, 32'h0, 6'h01, 32'h80ABCD12, 2'd0, 1, 32'h80000000, 32'h0, 4'h0, 32'hFFFFFF80, 1'b0);
        tbl[1]  = mk(3'd4, 2'd0, 32'h80000003, 32'h0, 6'h02, 32'h80ABCD12, 2'd0, 1, 32'h80000000, 32'h0, 4'h0, 32'h00000080, 1'b0);
        tbl[2]  = mk(3'd0, 2'd2, 32'h80000102, 32'h0000BEEF, 6'h03, 32'h0, 2'd0, 2, 32'h80000100, 32'hBEEF0000, 4'hC, 32'h0, 1'b0);
        tbl[3]  = mk(3'd3, 2'd0, 32'h80000001, 32'h0, 6'h04, 32'h0, 2'd0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
        tbl[4]  = mk(3'd0, 2'd0, 32'h00001234, 32'h0, 6'h15, 32'h0, 2'd0, 0, 32'h0, 32'h0, 4'h0, 32'h00001234, 1'b0);
        tbl[5]  = mk(3'd0, 2'd3, 32'h80000010, 32'hDEADBEEF, 6'h16, 32'h0, 2'd2, 2, 32'h80000010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b1);
        tbl[6]  = mk(3'd2, 2'd0, 32'h80000020, 32'h0, 6'h17, 32'h12345678, 2'd3, 1, 32'h80000020, 32'h0, 4'h0, 32'h0, 1'b1);
        tbl[7]  = mk(3'd0, 2'd1, 32'h80000001, 32'h000000A5, 6'h18, 32'h0, 2'd0, 2, 32'h80000000, 32'h0000A500, 4'h2, 32'h0, 1'b0);
        tbl[8]  = mk(3'd5, 2'd0, 32'h00000002, 32'h0, 6'h19, 32'h87654321, 2'd0, 1, 32'h0, 32'h0, 4'h0, 32'h00008765, 1'b0);
        tbl[9]  = mk(3'd2, 2'd0, 32'h00000002, 32'h0, 6'h1A, 32'h87654321, 2'd0, 1, 32'h0, 32'h0, 4'h0, 32'hFFFF8765, 1'b0);
        tbl[10] = mk(3'd3, 2'd1, 32'h00000003, 32'h00000011, 6'h1B, 32'h0, 2'd0, 2, 32'h0, 32'h11000000, 4'h8, 32'h0, 1'b0);
        tbl[11] = mk(3'd0, 2'd2, 32'h80000003, 32'h0, 6'h1C, 32'h0, 2'd0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
        tbl[12] = mk(3'd3, 2'd0, 32'h80000004, 32'h0, 6'h3F, 32'hCAFEF00D, 2'd0, 1, 32'h80000004, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
        tbl[13] = mk(3'd1, 2'd0, 32'h00000040, 32'h0, 6'h20, 32'h0000007F, 2'd0, 1, 32'h00000040, 32'h0, 4'h0, 32'h0000007F, 1'b0);

        rst = 1'b1; req_valid = 1'b0; req_addr = 0; req_wdata = 0; req_read = 0;
        req_write = 0; req_tag = 0; arready = 0; rdata = 0; rresp = 0; rvalid = 0;
        awready = 0; bresp = 0; bvalid = 0; wb_ready = 0;
        repeat (3) tick();
        rst = 1'b0;

        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset arvalid", 32'(arvalid), 32'd0);
        chk("reset awvalid", 32'(awvalid), 32'd0);
        chk("reset wb_valid", 32'(wb_valid), 32'd0);
        chk("reset wb_fault", 32'(wb_fault), 32'd0);
        chk("reset wb_data", wb_data, 32'd0);
        chk("reset wb_tag", 32'(wb_tag), 32'd0);
        chk("reset araddr", araddr, 32'd0);
        chk("reset wdata", wdata, 32'd0);
        chk("reset wstrb", 32'(wstrb), 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_txn(tbl[i], (i == 4) ? 0 : i % 3, (i + 1) % 2, (i == 4) ? 3 : i % 2,
                    $sformatf("vec%0d", i));
        end

        // Reset while in R: arready held off 4 cycles, then reset, then a
        // stale rvalid that must not produce a result.
        req_addr = 32'h80000100; req_read = 3'd3; req_write = 2'd0; req_tag = 6'h07;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rstR arvalid_hold", 32'(arvalid), 32'd1);
            chk("rstR araddr_hold", araddr, 32'h80000100);
            tick();
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("rstR in_R arvalid", 32'(arvalid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstR req_ready", 32'(req_ready), 32'd1);
        chk("rstR arvalid", 32'(arvalid), 32'd0);
        chk("rstR awvalid", 32'(awvalid), 32'd0);
        chk("rstR wb_valid", 32'(wb_valid), 32'd0);
        rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rstR stale wb_valid", 32'(wb_valid), 32'd0);
            chk("rstR stale req_ready", 32'(req_ready), 32'd1);
            tick();
        end
        $display("txn rstR reset during R, stale rvalid ignored");

        for (int n = 0; n < 80; n++) begin
            v.rd   = 3'($urandom_range(0, 5));
            v.wr   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            v.addr = $urandom;
            v.wd   = $urandom;
            v.tag  = 6'($urandom);
            v.rdat = $urandom;
            v.resp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            v.bus  = 0;
            v = model(v);
            run_txn(v, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                    $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
